// File: rtl/slt_serial.sv
`default_nettype none
// slt_serial: digit-serial set-on-less-than, LSB digit first, signed/unsigned.
// Rev 1.0 - initial release.

module slt_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  input  logic             is_unsigned,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] a_nxt;
  logic [WIDTH-1:0] b_nxt;
  logic             uns;
  logic             lt;
  logic             lt_next;
  logic             last;
  logic [CW-1:0]    cnt;

  assign last = (cnt == CW'(N - 1));
  assign busy = ~ready;

  // Operands shift right one digit per step, so the active digit is always at the bottom.
  generate
    if (DIGIT == WIDTH) begin : g_single
      assign a_nxt = '0;
      assign b_nxt = '0;
    end else begin : g_multi
      assign a_nxt = {{DIGIT{1'b0}}, a_sh[WIDTH-1:DIGIT]};
      assign b_nxt = {{DIGIT{1'b0}}, b_sh[WIDTH-1:DIGIT]};
    end
  endgenerate

  // Ripple the less-than flag across the digit; the signed MSB swaps the roles of a and b.
  always_comb begin
    lt_next = lt;
    for (int i = 0; i < DIGIT; i++) begin
      if (!uns && last && (i == DIGIT - 1)) begin
        lt_next = (a_sh[i] & ~b_sh[i]) | (~(a_sh[i] ^ b_sh[i]) & lt_next);
      end else begin
        lt_next = (b_sh[i] & ~a_sh[i]) | (~(a_sh[i] ^ b_sh[i]) & lt_next);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ready <= 1'b1;
      done  <= 1'b0;
      rd    <= '0;
      lt    <= 1'b0;
      cnt   <= '0;
      a_sh  <= '0;
      b_sh  <= '0;
      uns   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= rs;
            b_sh  <= rt;
            uns   <= is_unsigned;
            lt    <= 1'b0;
            cnt   <= '0;
            ready <= 1'b0;
            state <= RUN;
          end
        end
        RUN: begin
          lt   <= lt_next;
          cnt  <= cnt + CW'(1);
          a_sh <= a_nxt;
          b_sh <= b_nxt;
          if (last) begin
            rd    <= WIDTH'(lt_next);
            done  <= 1'b1;
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
          ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: doc/slt_serial.md
# slt_serial

Parametrised, multi-cycle set-on-less-than unit for the MIPS ALU datapath. Compares two WIDTH-bit operands DIGIT bits per clock, LSB digit first, propagating a running less-than flag between digits the same way the single-bit slt slices chain through the ALU. Supports signed (slt/slti) and unsigned (sltu/sltiu) modes. Uses a start/done handshake so the execute-stage controller can stall while the comparison runs.

## Interface
Parameters:
- WIDTH, 32, operand and result width; must be a multiple of DIGIT.
- DIGIT, 4, bits compared per cycle; 1 ≤ DIGIT ≤ WIDTH.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only on an edge where ready=1.
- rs  input  WIDTH  operand A; sampled only on the accepting edge.
- rt  input  WIDTH  operand B; sampled only on the accepting edge.
- is_unsigned  input  1  1 = sltu, 0 = slt; sampled only on the accepting edge.
- ready  output  1  high in IDLE.
- busy  output  1  high in RUN; always the inverse of ready.
- done  output  1  one-cycle pulse when rd is updated.
- rd  output  WIDTH  result {WIDTH-1 zeros, lt}; holds until the next result.

## Operation
- N = WIDTH/DIGIT digit steps; cnt is a counter of ceil(log2(N+1)) bits.
- States:
  - IDLE: ready=1.
    - start=1 → latch rs, rt, is_unsigned; clear lt=0 and cnt=0; go to RUN.
  - RUN: each edge processes digit cnt (bits cnt*DIGIT .. cnt*DIGIT+DIGIT-1) and increments cnt.
    - The edge that processes digit N-1 writes rd, pulses done and goes to IDLE.
- Per-bit rule, applied in order from the low bit to the high bit within a digit:
  - lt' = (b & ~a) | (~(a ^ b) & lt), where a = rs bit and b = rt bit.
- Signed mode: bit WIDTH-1 uses the swapped rule.
  - lt' = (a & ~b) | (~(a ^ b) & lt).
  - This is equivalent to inverting both MSBs.
- Equal operands → lt=0.
- No arithmetic overflow is possible; the result is purely a comparison.
- start while busy → ignored. It is not queued, and the latched operands are not disturbed.
- Input changes during RUN have no effect.

## Timing
- Reset values:
  - state = IDLE
  - ready = 1, busy = 0
  - done = 0
  - rd = 0
  - lt = 0, cnt = 0
- Reset takes priority over everything. Reset asserted mid-RUN:
  - aborts the operation with no done pulse;
  - rd is forced to 0.
- Latency: request accepted at edge E0; digits are processed at edges E1..EN.
  - done=1 and the new rd are visible in the cycle after EN.
  - ready=1 in that same cycle.
- Back-to-back: the earliest next accept is edge EN+1, so the issue interval is N+1 cycles.
- done is high for exactly one cycle per accepted request.
- rd changes only at the completing edge or on reset.
- DIGIT=WIDTH case: N=1, so done is asserted one cycle after the accept.

## Test plan
- Unsigned ordering, default parameters: rs=5, rt=7, is_unsigned=1, start pulsed.
  - done exactly 8 cycles after the accept edge, rd=0x00000001, ready=1 the same cycle.
- Signed vs unsigned on the same operands: rs=0xFFFFFFFF, rt=0x00000001.
  - is_unsigned=0 → rd=1.
  - is_unsigned=1 → rd=0.
- Sign boundary: rs=0x80000000, rt=0x7FFFFFFF.
  - Signed → rd=1.
  - Unsigned → rd=0.
- Equal operands: rs=rt=0x12345678 in both modes → rd=0.
- Difference only in the lowest digit: rs=0xABCD0000, rt=0xABCD0001 → rd=1.
  - Checks that lt propagates correctly through equal upper digits.
- Handshake and reset:
  - start re-asserted with new operands during RUN → ignored; result matches the first operands; single done pulse.
  - rst asserted at cycle 3 of RUN → next cycle ready=1, done=0, rd=0; a following request completes normally.
- Parameter sweep: WIDTH=8 with DIGIT=1, 2, 8; random signed/unsigned pairs against a reference model.
  - Latency is 8, 4 and 1 cycles respectively.
